rr_arbiter: RTL and testbench



---
 rtl/rr_arbiter_pkg.sv | 12 +
 rtl/rr_priority_pick.sv | 40 ++++
 rtl/rr_arbiter.sv | 53 +++++
 tb/tb_rr_arbiter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/rr_arbiter_pkg.sv
// Shared constants and sizing helpers for the round-robin arbiter.
// Anything that needs the arbiter's default width or pointer width imports this.
package rr_arbiter_pkg;

   localparam int RR_N = 4;

   // Width of an index into an N-entry request vector.
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority pick: the first set req bit at or above ptr
// (with wrap-around) wins, returned one-hot along with a valid flag.
module rr_priority_pick
   import rr_arbiter_pkg::*;
#(
   parameter int N     = RR_N,
   parameter int PTR_W = ptr_w(N)
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     win,
   output logic             valid
);

   logic [2*N-1:0] req_dbl;
   logic [2*N-1:0] pick_dbl;
   logic [N-1:0]   req_rot;
   logic [N-1:0]   pick_rot;

   // Rotate right by ptr so the highest-priority requester lands at bit 0.
   // ptr never exceeds N-1, so the doubled vector covers every rotation.
   always_comb begin
      req_dbl = {req, req} >> ptr;
      req_rot = req_dbl[N-1:0];
   end

   // Fixed LSB-first pick: isolate the lowest set bit.
   always_comb begin
      pick_rot = req_rot & (~req_rot + N'(1));
   end

   // Rotate the winner back into requester numbering.
   always_comb begin
      pick_dbl = {pick_rot, pick_rot} << ptr;
      win      = pick_dbl[2*N-1:N];
   end

   assign valid = |req;

endmodule

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: registered one-hot grant plus a rotating
// priority pointer that moves just past the most recent winner.
module rr_arbiter
   import rr_arbiter_pkg::*;
#(
   parameter int N = RR_N
) (
   input  logic         clk,
   input  logic         rst_an,
   input  logic [N-1:0] req,
   output logic [N-1:0] grant
);

   localparam int PTR_W = ptr_w(N);

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] ptr_nxt;
   logic [N-1:0]     win;
   logic             win_vld;

   rr_priority_pick #(
      .N     (N),
      .PTR_W (PTR_W)
   ) u_pick (
      .req   (req),
      .ptr   (ptr),
      .win   (win),
      .valid (win_vld)
   );

   // Next pointer is one past the winner, wrapping to 0 after N-1.
   // With no requests the pointer holds so priority is not disturbed by idle cycles.
   always_comb begin
      ptr_nxt = ptr;
      for (int i = 0; i < N; i++) begin
         if (win_vld && win[i]) begin
            ptr_nxt = (i == N - 1) ? '0 : PTR_W'(i + 1);
         end
      end
   end

   // rst_an is active-high despite its name.
   always_ff @(posedge clk or posedge rst_an) begin
      if (rst_an) begin
         grant <= '0;
         ptr   <= '0;
      end else begin
         grant <= win_vld ? win : '0;
         ptr   <= ptr_nxt;
      end
   end

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: directed sequences, async reset and a
// random phase checked against an independent search model.
module tb_rr_arbiter;

   localparam int N = 4;

   logic         clk;
   logic         rst_an;
   logic [N-1:0] req;
   logic [N-1:0] grant;

   logic [N-1:0] exp_q[$];
   int           n_tests;
   int           n_fail;
   int           mptr;

   rr_arbiter #(.N(N)) dut (
      .clk    (clk),
      .rst_an (rst_an),
      .req    (req),
      .grant  (grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: linear search from mptr with wrap-around.
   function automatic logic [N-1:0] model(input logic [N-1:0] r, inout int p);
      logic [N-1:0] g;
      int           k;
      g = '0;
      for (int j = 0; j < N; j++) begin
         k = (p + j) % N;
         if (r[k] && g == '0) begin
            g[k] = 1'b1;
            p    = (k + 1) % N;
         end
      end
      return g;
   endfunction

   // Drive one request vector, push its expected grant, compare after the edge.
   task automatic step(input string tag, input logic [N-1:0] r, input logic [N-1:0] e);
      logic [N-1:0] exp_v;
      @(negedge clk);
      req = r;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, grant, 'x);
      end else begin
         exp_v = exp_q.pop_front();
         chk(tag, grant, exp_v);
      end
      chk({tag, "_onehot"}, grant & (grant - N'(1)), '0);
      chk({tag, "_subset"}, grant & ~r, '0);
   endtask

   task automatic do_reset(input logic [N-1:0] r);
      @(negedge clk);
      req    = r;
      rst_an = 1'b1;
      #1;
      chk("rst_async", grant, '0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hold", grant, '0);
      @(negedge clk);
      rst_an = 1'b0;
      req    = '0;
   endtask

   initial begin
      logic [N-1:0] r;
      logic [N-1:0] e;
      n_tests = 0;
      n_fail  = 0;
      req     = '0;
      rst_an  = 1'b0;

      // Reset with random requests present.
      do_reset(N'($urandom_range(0, 15)));
      step("idle0", 4'b0000, 4'b0000);
      step("idle1", 4'b0000, 4'b0000);

      // Single requests, then rotation under contention.
      step("single0", 4'b0001, 4'b0001);
      step("single1", 4'b0010, 4'b0010);
      step("rot0", 4'b0101, 4'b0100);
      step("rot1", 4'b0101, 4'b0001);
      step("rot2", 4'b1101, 4'b0100);
      step("rot3", 4'b1000, 4'b1000);
      step("rot4", 4'b1111, 4'b0001);
      step("rot5", 4'b0011, 4'b0010);
      step("rot6", 4'b0110, 4'b0100);

      // Mid-operation reset: grant is 0100 here and must drop immediately.
      do_reset(N'($urandom_range(1, 15)));

      // Fairness from reset.
      for (int i = 0; i < 8; i++) begin
         e = 4'b0001 << (i % 4);
         step("fair", 4'b1111, e);
      end

      // Single holder, idle, then pointer still at 0.
      for (int i = 0; i < 3; i++) step("hold", 4'b1000, 4'b1000);
      step("idle_hold", 4'b0000, 4'b0000);
      step("after_idle", 4'b1001, 4'b0001);

      // Random traffic against the search model, from a fresh reset.
      do_reset(4'b0000);
      mptr = 0;
      for (int i = 0; i < 300; i++) begin
         r = N'($urandom_range(0, 15));
         e = model(r, mptr);
         step("rand", r, e);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
